// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the memory stage.
//   mem_state_t   : request FSM states (IDLE, WAIT)
//   RES_SEL_*     : writeback result-select encodings carried through MeWb
//   is_misaligned : word-alignment test on the low address bits
package cpu_pkg;

  typedef enum logic [0:0] {
    IDLE,
    WAIT
  } mem_state_t;

  localparam logic [1:0] RES_SEL_ALU = 2'd0;
  localparam logic [1:0] RES_SEL_MEM = 2'd1;
  localparam logic [1:0] RES_SEL_LR  = 2'd2;
  localparam logic [1:0] RES_SEL_PC  = 2'd3;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Memory request FSM with request latch.
// Issues the access combinationally from IDLE (zero-wait completion possible) and, when the
// memory does not acknowledge at once, latches addr/wdata/we and holds them in WAIT.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_en_i, req_we_i       : access request and store flag from EX/MEM
//   req_addr_i, req_wdata_i  : access address and store data from EX/MEM
//   misalign_i               : suppress the request (misaligned access)
//   mem_ack_i                : memory acknowledge
//   mem_req_o, mem_we_o      : memory request and write enable
//   mem_addr_o, mem_wdata_o  : memory address and write data
//   stall_o                  : access outstanding, freeze upstream
//   done_o                   : access completes this cycle
//   misalign_err_o           : misaligned request dropped this cycle
module mem_req_fsm
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        misalign_i,
  input  logic        mem_ack_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        misalign_err_o
);

  mem_state_t  state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q;
  logic        issue;
  logic        capture;

  assign issue   = req_en_i & ~misalign_i;
  // Capture only when a fresh request is not acknowledged in its first cycle.
  assign capture = (state_q == IDLE) & issue & ~mem_ack_i;

  // State register and request latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        we_q    <= req_we_i;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (issue && !mem_ack_i) state_d = WAIT;
      WAIT: if (mem_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = req_we_i;
    mem_addr_o     = req_addr_i;
    mem_wdata_o    = req_wdata_i;
    stall_o        = 1'b0;
    done_o         = 1'b0;
    misalign_err_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (issue) begin
          mem_req_o = 1'b1;
          stall_o   = ~mem_ack_i;
          done_o    = mem_ack_i;
        end
        misalign_err_o = req_en_i & misalign_i;
      end
      WAIT: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        stall_o     = ~mem_ack_i;
        done_o      = mem_ack_i;
      end
      default: ;
    endcase
    // Reset abandons any access; an ack arriving now is ignored.
    if (rst) begin
      mem_req_o      = 1'b0;
      stall_o        = 1'b0;
      done_o         = 1'b0;
      misalign_err_o = 1'b0;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: drives the memory request (via mem_req_fsm), stalls upstream while
// an access is outstanding, and holds the MEM/WB pipeline register.
// Optional feature: define MEM_ALIGN_CHECK_EN to drop misaligned accesses and pulse
// misalign_err; otherwise addresses pass unchanged and misalign_err is 0.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   ExMe_out_*                   : EX/MEM pipeline fields
//   mem_req/we/addr/wdata        : memory request side
//   mem_ack, mem_rdata           : memory response side
//   stall_mem                    : freeze upstream stages
//   misalign_err                 : one-cycle misaligned-access pulse
//   MeWb_out_*                   : registered MEM/WB fields
module memory_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ExMe_out_alu_out,
  input  logic [31:0] ExMe_out_reg_2,
  input  logic        ExMe_out_mem_en,
  input  logic        ExMe_out_mem_wrt,
  input  logic        ExMe_out_reg_wrt_en,
  input  logic [1:0]  ExMe_out_result_sel,
  input  logic [1:0]  ExMe_out_FL,
  input  logic [31:0] ExMe_out_LR,
  input  logic [31:0] ExMe_out_PC_next,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_mem,
  output logic [31:0] MeWb_out_mem_data,
  output logic [31:0] MeWb_out_alu_out,
  output logic        MeWb_out_reg_wrt_en,
  output logic [1:0]  MeWb_out_result_sel,
  output logic [1:0]  MeWb_out_FL,
  output logic [31:0] MeWb_out_LR,
  output logic [31:0] MeWb_out_PC_next,
  output logic        misalign_err
);

  logic misalign;
  logic done;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = ExMe_out_mem_en & is_misaligned(ExMe_out_alu_out[1:0]);
`else
  assign misalign = 1'b0;
`endif

  mem_req_fsm u_mem_req_fsm (
    .clk           (clk),
    .rst           (rst),
    .req_en_i      (ExMe_out_mem_en),
    .req_we_i      (ExMe_out_mem_wrt),
    .req_addr_i    (ExMe_out_alu_out),
    .req_wdata_i   (ExMe_out_reg_2),
    .misalign_i    (misalign),
    .mem_ack_i     (mem_ack),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .stall_o       (stall_mem),
    .done_o        (done),
    .misalign_err_o(misalign_err)
  );

  logic [31:0] mem_data_q, mem_data_d;
  logic [31:0] alu_out_q, alu_out_d;
  logic        reg_wrt_en_q, reg_wrt_en_d;
  logic [1:0]  result_sel_q, result_sel_d;
  logic [1:0]  fl_q, fl_d;
  logic [31:0] lr_q, lr_d;
  logic [31:0] pc_next_q, pc_next_d;

  always_comb begin
    mem_data_d   = mem_data_q;
    alu_out_d    = alu_out_q;
    reg_wrt_en_d = reg_wrt_en_q;
    result_sel_d = result_sel_q;
    fl_d         = fl_q;
    lr_d         = lr_q;
    pc_next_d    = pc_next_q;
    if (stall_mem || misalign_err) begin
      // Bubble: only the write enable is cleared, the rest hold.
      reg_wrt_en_d = 1'b0;
    end else begin
      mem_data_d   = (done && !mem_we) ? mem_rdata : 32'd0;
      alu_out_d    = ExMe_out_alu_out;
      reg_wrt_en_d = ExMe_out_reg_wrt_en;
      result_sel_d = ExMe_out_result_sel;
      fl_d         = ExMe_out_FL;
      lr_d         = ExMe_out_LR;
      pc_next_d    = ExMe_out_PC_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data_q   <= '0;
      alu_out_q    <= '0;
      reg_wrt_en_q <= 1'b0;
      result_sel_q <= '0;
      fl_q         <= '0;
      lr_q         <= '0;
      pc_next_q    <= '0;
    end else begin
      mem_data_q   <= mem_data_d;
      alu_out_q    <= alu_out_d;
      reg_wrt_en_q <= reg_wrt_en_d;
      result_sel_q <= result_sel_d;
      fl_q         <= fl_d;
      lr_q         <= lr_d;
      pc_next_q    <= pc_next_d;
    end
  end

  assign MeWb_out_mem_data   = mem_data_q;
  assign MeWb_out_alu_out    = alu_out_q;
  assign MeWb_out_reg_wrt_en = reg_wrt_en_q;
  assign MeWb_out_result_sel = result_sel_q;
  assign MeWb_out_FL         = fl_q;
  assign MeWb_out_LR         = lr_q;
  assign MeWb_out_PC_next    = pc_next_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized instruction
// stream against a per-instruction transaction model.
module tb_memory_stage;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ExMe_out_alu_out, ExMe_out_reg_2, ExMe_out_LR, ExMe_out_PC_next;
  logic        ExMe_out_mem_en, ExMe_out_mem_wrt, ExMe_out_reg_wrt_en;
  logic [1:0]  ExMe_out_result_sel, ExMe_out_FL;
  logic        mem_req, mem_we, mem_ack, stall_mem, misalign_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] MeWb_out_mem_data, MeWb_out_alu_out, MeWb_out_LR, MeWb_out_PC_next;
  logic        MeWb_out_reg_wrt_en;
  logic [1:0]  MeWb_out_result_sel, MeWb_out_FL;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk                (clk),
    .rst                (rst),
    .ExMe_out_alu_out   (ExMe_out_alu_out),
    .ExMe_out_reg_2     (ExMe_out_reg_2),
    .ExMe_out_mem_en    (ExMe_out_mem_en),
    .ExMe_out_mem_wrt   (ExMe_out_mem_wrt),
    .ExMe_out_reg_wrt_en(ExMe_out_reg_wrt_en),
    .ExMe_out_result_sel(ExMe_out_result_sel),
    .ExMe_out_FL        (ExMe_out_FL),
    .ExMe_out_LR        (ExMe_out_LR),
    .ExMe_out_PC_next   (ExMe_out_PC_next),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_ack            (mem_ack),
    .mem_rdata          (mem_rdata),
    .stall_mem          (stall_mem),
    .MeWb_out_mem_data  (MeWb_out_mem_data),
    .MeWb_out_alu_out   (MeWb_out_alu_out),
    .MeWb_out_reg_wrt_en(MeWb_out_reg_wrt_en),
    .MeWb_out_result_sel(MeWb_out_result_sel),
    .MeWb_out_FL        (MeWb_out_FL),
    .MeWb_out_LR        (MeWb_out_LR),
    .MeWb_out_PC_next   (MeWb_out_PC_next),
    .misalign_err       (misalign_err)
  );

  int n_chk = 0;
  int n_err = 0;

  // Expected MEM/WB register contents
  logic [31:0] e_mem_data, e_alu, e_lr, e_pc;
  logic        e_wen;
  logic [1:0]  e_rsel, e_fl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    e_mem_data = '0; e_alu = '0; e_lr = '0; e_pc = '0;
    e_wen = 1'b0; e_rsel = '0; e_fl = '0;
  endtask

  task automatic check_mewb();
    chk("mewb_mem_data", MeWb_out_mem_data, e_mem_data);
    chk("mewb_alu_out", MeWb_out_alu_out, e_alu);
    chk("mewb_reg_wrt_en", {31'd0, MeWb_out_reg_wrt_en}, {31'd0, e_wen});
    chk("mewb_result_sel", {30'd0, MeWb_out_result_sel}, {30'd0, e_rsel});
    chk("mewb_fl", {30'd0, MeWb_out_FL}, {30'd0, e_fl});
    chk("mewb_lr", MeWb_out_LR, e_lr);
    chk("mewb_pc_next", MeWb_out_PC_next, e_pc);
  endtask

  // One instruction through the stage; the memory acknowledges d cycles after the request.
  // Called at posedge+1; returns at posedge+1 after the instruction leaves the stage.
  task automatic run_instr(input logic en, input logic wrt, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] rsel, input logic [1:0] fl,
                           input logic [31:0] lr, input logic [31:0] pc,
                           input int d, input logic [31:0] rdata);
    logic mis, acc;
    int   dd;
    mis = AlignChk && en && (addr[1:0] != 2'b00);
    acc = en && !mis;
    dd  = acc ? d : 0;
    ExMe_out_mem_en = en; ExMe_out_mem_wrt = wrt; ExMe_out_reg_wrt_en = wen;
    ExMe_out_alu_out = addr; ExMe_out_reg_2 = wdata; ExMe_out_result_sel = rsel;
    ExMe_out_FL = fl; ExMe_out_LR = lr; ExMe_out_PC_next = pc;
    for (int c = 0; c <= dd; c++) begin
      // Without an access, random acks probe that stray acks are ignored.
      mem_ack   = acc ? (c == dd) : ($urandom_range(0, 1) == 1);
      mem_rdata = (c == dd) ? rdata : $urandom;
      // Disturb non-pass-through inputs while waiting; the request must stay latched.
      if (c > 0) begin
        ExMe_out_reg_2   = $urandom;
        ExMe_out_mem_wrt = ($urandom_range(0, 1) == 1);
        ExMe_out_alu_out = (c == dd) ? addr : $urandom;
      end
      @(negedge clk);
      chk("mem_req", {31'd0, mem_req}, {31'd0, acc});
      chk("stall_mem", {31'd0, stall_mem}, {31'd0, acc && (c < dd)});
      chk("misalign_err", {31'd0, misalign_err}, {31'd0, mis});
      if (acc) begin
        chk("mem_addr", mem_addr, addr);
        chk("mem_wdata", mem_wdata, wdata);
        chk("mem_we", {31'd0, mem_we}, {31'd0, wrt});
      end
      @(posedge clk);
      #1;
      if (acc && (c < dd)) e_wen = 1'b0;
      else if (mis) e_wen = 1'b0;
      else begin
        e_mem_data = (acc && !wrt) ? rdata : 32'd0;
        e_alu = addr; e_wen = wen; e_rsel = rsel; e_fl = fl; e_lr = lr; e_pc = pc;
      end
      check_mewb();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    // Request asserted during reset must not reach memory.
    ExMe_out_mem_en = 1'b1; ExMe_out_mem_wrt = 1'b0; ExMe_out_reg_wrt_en = 1'b1;
    ExMe_out_alu_out = 32'h40; ExMe_out_reg_2 = 32'h1; ExMe_out_result_sel = 2'd1;
    ExMe_out_FL = 2'd3; ExMe_out_LR = 32'h11; ExMe_out_PC_next = 32'h22;
    mem_ack = 1'b0; mem_rdata = 32'hA5A5A5A5;
    model_zero();
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_stall", {31'd0, stall_mem}, 32'd0);
      chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
      @(posedge clk);
      #1;
      check_mewb();
    end
    rst = 1'b0;

    // Zero-wait load
    run_instr(1, 0, 1, 32'h100, 32'h0, 2'd1, 2'd0, 32'h0, 32'h104, 0, 32'hDEADBEEF);
    // Store with 3-cycle ack delay
    run_instr(1, 1, 0, 32'h200, 32'h12345678, 2'd0, 2'd1, 32'h8, 32'h208, 3, 32'h0);
    // Non-memory op
    run_instr(0, 0, 1, 32'h55, 32'h9, 2'd0, 2'd2, 32'h33, 32'h44, 0, 32'h0);
    // Waited load immediately followed by a zero-wait load
    run_instr(1, 0, 1, 32'h300, 32'h0, 2'd1, 2'd0, 32'h1, 32'h2, 2, 32'hCAFEF00D);
    run_instr(1, 0, 1, 32'h304, 32'h0, 2'd1, 2'd3, 32'h3, 32'h4, 0, 32'h0BADF00D);
    // Misaligned load
    run_instr(1, 0, 1, 32'h102, 32'h0, 2'd1, 2'd1, 32'h5, 32'h6, 1, 32'h77777777);

    // Reset while waiting, then a late ack
    ExMe_out_mem_en = 1'b1; ExMe_out_mem_wrt = 1'b1; ExMe_out_reg_wrt_en = 1'b0;
    ExMe_out_alu_out = 32'h400; ExMe_out_reg_2 = 32'h99; mem_ack = 1'b0;
    @(negedge clk);
    chk("wait_mem_req", {31'd0, mem_req}, 32'd1);
    chk("wait_stall", {31'd0, stall_mem}, 32'd1);
    @(posedge clk);
    #1;
    e_wen = 1'b0;
    check_mewb();
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstwait_stall", {31'd0, stall_mem}, 32'd0);
    @(posedge clk);
    #1;
    model_zero();
    check_mewb();
    rst = 1'b0;
    ExMe_out_mem_en = 1'b0; ExMe_out_mem_wrt = 1'b0; ExMe_out_reg_wrt_en = 1'b0;
    ExMe_out_alu_out = '0; ExMe_out_reg_2 = '0; ExMe_out_result_sel = '0;
    ExMe_out_FL = '0; ExMe_out_LR = '0; ExMe_out_PC_next = '0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("lateack_mem_req", {31'd0, mem_req}, 32'd0);
    chk("lateack_stall", {31'd0, stall_mem}, 32'd0);
    @(posedge clk);
    #1;
    check_mewb();
    mem_ack = 1'b0;
    // FSM must be back in IDLE: a fresh access uses the live address
    run_instr(1, 0, 1, 32'h500, 32'h0, 2'd1, 2'd2, 32'h7, 32'h8, 0, 32'h13572468);

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      run_instr(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), $urandom, $urandom,
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
